// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C configuration write sequencer.
package i2c_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_START_HOLD,
    ST_SHIFT,
    ST_ACK,
    ST_STOP,
    ST_STOP_HOLD,
    ST_DONE
  } i2c_state_t;

  localparam int BYTES_PER_CMD = 3;
  localparam int BITS_PER_BYTE = 8;

  localparam int CMD_W       = BYTES_PER_CMD * BITS_PER_BYTE;
  localparam int CMD_DEV_LSB = 16;
  localparam int CMD_REG_LSB = 8;
  localparam int CMD_DAT_LSB = 0;
  localparam int CMD_DEV_MSB = CMD_DEV_LSB + BITS_PER_BYTE - 1;

endpackage

// File: rtl/Altera_UP_Slow_Clock_Generator.sv
// Divides clk by 2^COUNTER_BITS/COUNTER_INC; new_clk and all strobes are registered,
// so each strobe is high one cycle after its counter condition. No backpressure.
module Altera_UP_Slow_Clock_Generator #(
  parameter int COUNTER_BITS = 10,
  parameter int COUNTER_INC  = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_clk,
  output logic new_clk,
  output logic rising_edge,
  output logic falling_edge,
  output logic middle_of_high_level,
  output logic middle_of_low_level
);

  logic [COUNTER_BITS-1:0] cnt_q, cnt_d;
  logic new_clk_q, new_clk_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic mid_high_q, mid_high_d;
  logic mid_low_q, mid_low_d;
  logic cnt_msb, mid_tail;

  always_comb begin
    cnt_d      = enable_clk ? cnt_q + COUNTER_BITS'(COUNTER_INC) : cnt_q;
    cnt_msb    = cnt_q[COUNTER_BITS-1];
    // Mid-level point: second-MSB clear, all lower bits set.
    mid_tail   = ~cnt_q[COUNTER_BITS-2] & (&cnt_q[COUNTER_BITS-3:0]);
    new_clk_d  = cnt_msb;
    rise_d     = cnt_msb & ~new_clk_q;
    fall_d     = ~cnt_msb & new_clk_q;
    mid_high_d = cnt_msb & mid_tail;
    mid_low_d  = ~cnt_msb & mid_tail;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      new_clk_q  <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      mid_high_q <= 1'b0;
      mid_low_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      new_clk_q  <= new_clk_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      mid_high_q <= mid_high_d;
      mid_low_q  <= mid_low_d;
    end
  end

  assign new_clk              = new_clk_q;
  assign rising_edge          = rise_q;
  assign falling_edge         = fall_q;
  assign middle_of_high_level = mid_high_q;
  assign middle_of_low_level  = mid_low_q;

endmodule

// File: rtl/i2c_config_sequencer.sv
// Sends one 24-bit command as an I2C write (start, 3 bytes + ack slots, stop) in 29 SCL periods.
// cmd_ready is high only while idle; a NACK skips the remaining bytes but still issues stop and done.
module i2c_config_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int COUNTER_BITS = 10,
  parameter int COUNTER_INC  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CMD_W-1:0] cmd_data,
  output logic             busy,
  output logic             done,
  output logic             ack_error,
  output logic             i2c_sclk,
  output logic             i2c_sdat_oe,
  input  logic             i2c_sdat_in
);

  i2c_state_t       state_q, state_d;
  logic [CMD_W-1:0] shreg_q, shreg_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ack_error_q, ack_error_d;
  logic             sclk_q, sclk_d;
  logic             sdat_oe_q, sdat_oe_d;

  logic gen_reset, new_clk, fall, mid_high, mid_low, gen_rise_unused;

  // Holding the generator in reset while idle aligns every transaction to counter 0.
  assign gen_reset = reset | (state_q == ST_IDLE);

  Altera_UP_Slow_Clock_Generator #(
    .COUNTER_BITS(COUNTER_BITS),
    .COUNTER_INC (COUNTER_INC)
  ) u_slow_clk (
    .clk                 (clk),
    .reset               (gen_reset),
    .enable_clk          (1'b1),
    .new_clk             (new_clk),
    .rising_edge         (gen_rise_unused),
    .falling_edge        (fall),
    .middle_of_high_level(mid_high),
    .middle_of_low_level (mid_low)
  );

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ack_error_d = ack_error_q;
    sclk_d      = 1'b1;
    sdat_oe_d   = sdat_oe_q;
    unique case (state_q)
      ST_IDLE: begin
        sdat_oe_d = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          shreg_d     = cmd_data;
          ack_error_d = 1'b0;
          bit_cnt_d   = '0;
          byte_cnt_d  = '0;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        if (mid_high) begin
          sdat_oe_d = 1'b1;
          state_d   = ST_START_HOLD;
        end
      end
      ST_START_HOLD: begin
        sclk_d = new_clk;
        if (fall) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        sclk_d = new_clk;
        if (mid_low && bit_cnt_q != 4'(BITS_PER_BYTE)) begin
          sdat_oe_d = ~shreg_q[CMD_DEV_MSB];
          shreg_d   = {shreg_q[CMD_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        if (fall && bit_cnt_q == 4'(BITS_PER_BYTE)) state_d = ST_ACK;
      end
      ST_ACK: begin
        sclk_d = new_clk;
        if (mid_low) sdat_oe_d = 1'b0;
        if (mid_high && i2c_sdat_in) ack_error_d = 1'b1;
        if (fall) begin
          if (ack_error_q || byte_cnt_q == 2'(BYTES_PER_CMD - 1)) begin
            state_d = ST_STOP;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            bit_cnt_d  = '0;
            state_d    = ST_SHIFT;
          end
        end
      end
      ST_STOP: begin
        sclk_d = new_clk;
        if (mid_low) sdat_oe_d = 1'b1;
        if (mid_high) begin
          sdat_oe_d = 1'b0;
          state_d   = ST_STOP_HOLD;
        end
      end
      ST_STOP_HOLD: begin
        if (mid_low) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_error_q <= 1'b0;
      sclk_q      <= 1'b1;
      sdat_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ack_error_q <= ack_error_d;
      sclk_q      <= sclk_d;
      sdat_oe_q   <= sdat_oe_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_error   = ack_error_q;
  assign i2c_sclk    = sclk_q;
  assign i2c_sdat_oe = sdat_oe_q;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Randomized bench: open-drain bus/slave model decodes the wire and is compared with
// byte/ack/timing expectations derived from the command and the slave's NACK plan.
module tb_i2c_config_sequencer;
  import i2c_cfg_pkg::*;

  localparam int CB = 4;
  localparam int P  = 1 << CB;

  logic             clk       = 1'b0;
  logic             reset     = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [CMD_W-1:0] cmd_data  = '0;
  logic             cmd_ready, busy, done, ack_error, i2c_sclk, i2c_sdat_oe, i2c_sdat_in;
  logic             slave_pull = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Driver-owned: NACK plan for the current command and a request to clear per-command stats.
  logic [2:0] cur_nack = '0;
  int         clr_seq  = 0;

  // Monitor-owned state.
  int         seen_seq = 0;
  logic [7:0] rx_q[$];
  logic [7:0] shbyte = '0;
  int bitpos = 0, starts = 0, stops = 0, rises = 0, done_cnt = 0;
  int viol_rb = 0, viol_dd = 0, idle_low = 0;
  logic prev_scl = 1'b1, prev_oe = 1'b0, prev_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign i2c_sdat_in = ~(i2c_sdat_oe | slave_pull);

  i2c_config_sequencer #(.COUNTER_BITS(CB), .COUNTER_INC(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .busy       (busy),
    .done       (done),
    .ack_error  (ack_error),
    .i2c_sclk   (i2c_sclk),
    .i2c_sdat_oe(i2c_sdat_oe),
    .i2c_sdat_in(i2c_sdat_in)
  );

  // Bus monitor and ACKing slave, evaluated on the falling clock edge.
  always @(negedge clk) begin
    if (clr_seq != seen_seq) begin
      seen_seq = clr_seq;
      rx_q.delete();
      starts = 0; stops = 0; rises = 0; done_cnt = 0; bitpos = 0;
    end
    if (reset) begin
      slave_pull = 1'b0;
    end else begin
      if (cmd_ready && busy) viol_rb++;
      if (done && prev_done) viol_dd++;
      if (done) done_cnt++;
      if (!busy && !i2c_sclk) idle_low++;
      if (prev_scl && i2c_sclk && (i2c_sdat_oe != prev_oe)) begin
        if (i2c_sdat_oe) begin
          starts++;
          bitpos = 0;
        end else begin
          stops++;
        end
      end
      if (i2c_sclk && !prev_scl) begin
        rises++;
        shbyte = {shbyte[6:0], i2c_sdat_in};
        if (bitpos % 9 == 7) rx_q.push_back(shbyte);
        bitpos++;
      end
      if (!i2c_sclk && prev_scl)
        slave_pull = (bitpos % 9 == 8) && (bitpos / 9 < BYTES_PER_CMD) && !cur_nack[bitpos / 9];
    end
    prev_scl  = i2c_sclk;
    prev_oe   = i2c_sdat_oe;
    prev_done = done;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int bytes_sent(input logic [2:0] nack);
    for (int i = 0; i < BYTES_PER_CMD; i++)
      if (nack[i]) return i + 1;
    return BYTES_PER_CMD;
  endfunction

  task automatic handshake(input logic [CMD_W-1:0] data, input logic [2:0] nack,
                           input bit keep, output int hs);
    hs        = -1;
    cmd_data  = data;
    cmd_valid = 1'b1;
    for (int k = 0; k < 4 * P; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        hs = cyc;
        break;
      end
    end
    chk("accept_seen", 32'(hs >= 0), 1);
    @(posedge clk); #1;
    if (!keep) cmd_valid = 1'b0;
    cur_nack = nack;
    clr_seq++;
    chk("busy_after_accept", 32'(busy), 1);
    chk("ready_after_accept", 32'(cmd_ready), 0);
    chk("ack_err_clr_on_accept", 32'(ack_error), 0);
  endtask

  task automatic wait_done(input logic [CMD_W-1:0] data, input logic [2:0] nack,
                           input int hs, output int dcyc);
    int n;
    int per;
    logic [7:0] exp_b[3];
    n    = bytes_sent(nack);
    per  = 2 + 9 * n;
    exp_b[0] = data[CMD_DEV_LSB +: BITS_PER_BYTE];
    exp_b[1] = data[CMD_REG_LSB +: BITS_PER_BYTE];
    exp_b[2] = data[CMD_DAT_LSB +: BITS_PER_BYTE];
    dcyc = -1;
    for (int k = 0; k < 40 * P; k++) begin
      @(negedge clk);
      if (done) begin
        dcyc = cyc;
        break;
      end
    end
    chk("done_seen", 32'(dcyc >= 0), 1);
    @(posedge clk); #1;
    chk("done_in_window", 32'((dcyc - hs >= per * P) && (dcyc - hs <= per * P + P / 4 + 4)), 1);
    chk("byte_count", 32'(rx_q.size()), 32'(n));
    for (int i = 0; i < n; i++)
      chk("rx_byte", (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hDEAD_BEEF, 32'(exp_b[i]));
    chk("scl_pulses", 32'(rises), 32'(9 * n + 1));
    chk("start_count", 32'(starts), 1);
    chk("stop_count", 32'(stops), 1);
    chk("done_count", 32'(done_cnt), 1);
    chk("ack_error", 32'(ack_error), 32'(nack != 3'b000));
  endtask

  task automatic reset_mid(input logic [CMD_W-1:0] data, input logic [2:0] nack, input int mode);
    int hs;
    bit hit;
    hit = 1'b0;
    handshake(data, nack, 1'b0, hs);
    for (int k = 0; k < 40 * P; k++) begin
      @(posedge clk); #1;
      if ((mode == 0 && bitpos == 9 + 4) || (mode == 1 && ack_error)) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reset_point_reached", 32'(hit), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_sclk", 32'(i2c_sclk), 1);
    chk("rst_mid_oe", 32'(i2c_sdat_oe), 0);
    chk("rst_mid_ready", 32'(cmd_ready), 1);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_done", 32'(done), 0);
    chk("rst_mid_ack_error", 32'(ack_error), 0);
    repeat (3 * P) @(posedge clk);
    #1;
    chk("no_done_after_reset", 32'(done_cnt), 0);
  endtask

  initial begin
    int hs, hs2, dc;
    logic [CMD_W-1:0] d, d2;
    logic [2:0] nk;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ack_error", 32'(ack_error), 0);
    chk("rst_sclk", 32'(i2c_sclk), 1);
    chk("rst_oe", 32'(i2c_sdat_oe), 0);

    // Normal write.
    handshake(24'h34_0A_5F, 3'b000, 1'b0, hs);
    wait_done(24'h34_0A_5F, 3'b000, hs, dc);

    // NACK on the register byte; the following accept clears ack_error.
    d = CMD_W'($urandom);
    handshake(d, 3'b010, 1'b0, hs);
    wait_done(d, 3'b010, hs, dc);

    // Back-to-back with cmd_valid held high.
    d  = CMD_W'($urandom);
    d2 = CMD_W'($urandom);
    handshake(d, 3'b000, 1'b1, hs);
    cmd_data = d2;
    wait_done(d, 3'b000, hs, dc);
    handshake(d2, 3'b000, 1'b0, hs2);
    chk("b2b_accept_cycle", 32'(hs2), 32'(dc + 1));
    wait_done(d2, 3'b000, hs2, dc);

    // Reset mid-byte, then reset while a NACK is flagged; each followed by a clean write.
    reset_mid(CMD_W'($urandom), 3'b000, 0);
    d = CMD_W'($urandom);
    handshake(d, 3'b000, 1'b0, hs);
    wait_done(d, 3'b000, hs, dc);
    reset_mid(CMD_W'($urandom), 3'b001, 1);

    // Randomized commands, gaps and NACK plans.
    for (int t = 0; t < 10; t++) begin
      d  = CMD_W'($urandom);
      nk = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      repeat ($urandom_range(0, 20)) @(posedge clk);
      #1;
      handshake(d, nk, 1'b0, hs);
      wait_done(d, nk, hs, dc);
    end

    chk("ready_while_busy", 32'(viol_rb), 0);
    chk("done_two_cycles", 32'(viol_dd), 0);
    chk("scl_low_while_idle", 32'(idle_low), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2c_config_sequencer.md
# i2c_config_sequencer

Serial-bus write sequencer for the audio/video configuration path. Accepts one 24-bit write command (device address byte, register byte, data byte) over a valid/ready handshake and transmits it as an I2C-style write: start, three 8-bit bytes each followed by an acknowledge slot, then stop. Bus timing comes from an internal instance of the slow clock generator; the sequencer gates its counter and uses its edge and mid-level strobes to place every data change and sample point.

## Interface
Parameters:
- COUNTER_BITS, default 10: slow-clock counter width. Counter width must be ≥ 3.
- COUNTER_INC, default 1: counter increment. SCL period P = 2^COUNTER_BITS / COUNTER_INC clk cycles.

Ports:
- clk  in  1  system clock. One clock domain.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_data  in  24  [23:16] device address + R/W̄ (transmitted as given), [15:8] register, [7:0] data.
- busy  out  1  high from acceptance through the done cycle.
- done  out  1  one-cycle pulse at the end of a transaction.
- ack_error  out  1  sticky NACK flag. Cleared on acceptance of the next command.
- i2c_sclk  out  1  serial clock.
- i2c_sdat_oe  out  1  1 = pull SDA low; 0 = release.
- i2c_sdat_in  in  1  sampled SDA level.

## Operation
- Generator instance: its reset is `reset | (state==IDLE)`; its enable_clk is tied high. Every transaction therefore starts at counter 0 with new_clk low.
- States: IDLE, START, START_HOLD, SHIFT, ACK, STOP, STOP_HOLD, DONE.
- IDLE:
  - SCL = 1, SDA released.
  - cmd_valid & cmd_ready latches cmd_data into a 24-bit shift register, clears ack_error, goes to START.
- START:
  - SCL forced 1.
  - On middle_of_high_level, set sdat_oe = 1 (start condition) and go to START_HOLD.
- START_HOLD: on falling_edge, go to SHIFT. From here SCL follows new_clk.
- SHIFT:
  - On middle_of_low_level, sdat_oe = ~shreg[23], shift left, bit_cnt++.
  - On the falling_edge after bit 8, go to ACK.
- ACK:
  - On middle_of_low_level, release SDA.
  - On middle_of_high_level, sample i2c_sdat_in; 1 sets ack_error.
  - On falling_edge: if ack_error or byte_cnt == 2, go to STOP; otherwise byte_cnt++, bit_cnt = 0, go to SHIFT.
- STOP:
  - On middle_of_low_level, sdat_oe = 1.
  - On middle_of_high_level, release SDA (stop condition) and go to STOP_HOLD.
- STOP_HOLD: SCL forced 1. On the next middle_of_low_level strobe, go to DONE.
- DONE: done = 1 for one cycle, then IDLE.
- NACK on any byte: remaining bytes are skipped; stop and done are still issued; ack_error = 1.
- Counters:
  - bit_cnt is 4 bits and takes values 0–8.
  - byte_cnt is 2 bits and takes values 0–2.
  - Neither counter wraps; both are cleared on acceptance.

## Timing
- Reset values: cmd_ready 1, busy 0, done 0, ack_error 0, i2c_sclk 1, i2c_sdat_oe 0, state IDLE, generator counter 0.
- Reset in the middle of a transaction takes effect on the next edge: all outputs return to their reset values (SCL high, SDA released, no done pulse, ack_error cleared).
- cmd_ready falls the cycle after acceptance.
- When cmd_valid is high during DONE, it is not accepted; it is accepted in the following IDLE cycle.
- Generator strobes arrive registered: one cycle after the counter condition. The sequencer acts on a strobe in the cycle it is high.
- i2c_sclk and i2c_sdat_oe are registered outputs.
- A full 3-byte transaction takes 29 SCL periods: 1 start, 27 bit/ack slots, 1 stop. done pulses in the window 29·P to 29·P+P/4+4 cycles after the handshake.
- SDA changes only while SCL is low, except the start and stop transitions, which occur at mid-high.

## Structure
- Package i2c_cfg_pkg holds:
  - state enum `i2c_state_t`
  - `BYTES_PER_CMD = 3`
  - `BITS_PER_BYTE = 8`
  - command field offsets
- One sub-module: Altera_UP_Slow_Clock_Generator, instantiated unchanged with COUNTER_BITS and COUNTER_INC passed through.
- Target size: roughly 200 lines of RTL.

## Test plan
Run all scenarios with COUNTER_BITS = 4 (P = 16) and a bus model that ACKs unless told otherwise.
- Normal write: cmd_data = 24'h34_0A_5F, all ACK → the bus model decodes bytes 0x34, 0x0A, 0x5F; a start before the first byte and a stop after the last; done exactly once within the timing window; ack_error = 0.
- NACK on byte 2: model NACKs the register byte → no SCL pulses for byte 3, stop is issued, done pulses, ack_error = 1; ack_error clears on the next accepted command.
- Back-to-back: cmd_valid held high with two commands → second accepted the cycle after done; no SCL glitch between transactions; SCL stays high through IDLE.
- Reset at mid-byte (bit 4 of byte 1): next cycle i2c_sclk = 1, sdat_oe = 0, cmd_ready = 1, no done; a new command then completes normally.
- Protocol checker for the whole run: SDA changes only with SCL low, except start/stop; cmd_ready = 0 whenever busy = 1; done is never high for two consecutive cycles.
